// File: rtl/core_pkg.sv
// Shared core types and constants used by the pipeline controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package core_pkg;

  // Register file address width shared across the core.
  localparam int REG_ADDR_WIDTH = 5;

  // Default memory watchdog limit, in consecutive wait cycles.
  localparam int MEM_WAIT_MAX_DEFAULT = 15;

  // Width of the memory wait counter; bounds MEM_WAIT_MAX to 1..255.
  localparam int WAIT_CNT_WIDTH = 8;

  // Pipeline control sequencer states. Encoding 3 is unused.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of the instruction in ID.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the result feeds the stall priority logic in pipeline_ctrl.
//
// Ports:
//   id_rs1_addr/id_rs2_addr  sources of the ID instruction
//   id_rs1_used/id_rs2_used  the ID instruction really reads that source
//   ex_rd_addr               destination of the EX instruction
//   ex_mem_read              the EX instruction is a load
//   lu_hazard                ID needs a value the EX load has not produced yet
module hazard_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_mem_read,
  output logic                      lu_hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_match = id_rs2_used && (id_rs2_addr == ex_rd_addr);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu_hazard = ex_mem_read && (ex_rd_addr != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: load-use, EX redirect and data-memory wait -> per-stage strobes, plus memory watchdog.
// Latency: strobes are combinational (0 cycles) from inputs and registered state; state/flags update on clk rise.
// Backpressure: mem_req && !mem_ready freezes all stages; watchdog timeout halts the core until reset.
//
// Optional feature macro: PIPELINE_CTRL_PERF_EN enables the three performance counters;
// when undefined the counter ports are tied to 0 and no counter registers exist.
//
// Ports:
//   clk, rst_n                  core clock, synchronous active-low reset
//   id_* / ex_rd_addr / ex_mem_read   load-use hazard inputs
//   ex_branch_taken             taken branch/jump resolved in EX
//   mem_req, mem_ready          MEM stage request and data-memory completion
//   pc_en..exmem_en             stage register update enables
//   ifid_flush, idex_flush      load a bubble into that register (wins over enable)
//   memwb_bubble                MEM/WB captures a bubble instead of MEM results
//   ctrl_state, mem_timeout     sequencer state and sticky watchdog flag
//   perf_*                      stall-cycle, load-use and flush counters
module pipeline_ctrl
  import core_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH,
  parameter int MEM_WAIT_MAX   = MEM_WAIT_MAX_DEFAULT,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_mem_read,
  input  logic                      ex_branch_taken,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      pc_en,
  output logic                      ifid_en,
  output logic                      idex_en,
  output logic                      exmem_en,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      memwb_bubble,
  output ctrl_state_e               ctrl_state,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      perf_stall_cycles,
  output logic [CNT_WIDTH-1:0]      perf_lu_count,
  output logic [CNT_WIDTH-1:0]      perf_flush_count
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX = WAIT_CNT_WIDTH'(MEM_WAIT_MAX);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_ONE = WAIT_CNT_WIDTH'(1);

  ctrl_state_e               state;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  logic                      timeout_q;
  logic                      lu_hazard;
  logic                      mem_stall;

  hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd_addr  (ex_rd_addr),
    .ex_mem_read (ex_mem_read),
    .lu_hazard   (lu_hazard)
  );

  // Memory stalls only count while the sequencer is live; HALT and the
  // illegal encoding never report one.
  assign mem_stall = ((state == RUN) || (state == MEM_WAIT)) && mem_req && !mem_ready;

  // Strobe priority: reset > HALT > memory stall > taken branch > load-use > normal.
  // A branch held under a memory stall is not lost: EX is frozen and the
  // branch is re-presented once memory releases.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (state == HALT || mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is squashed, so any load-use match is moot.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_hazard) begin
      // Hold PC and IF/ID, push one bubble into ID/EX; next cycle EX holds the
      // bubble and the hazard disappears on its own.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign ctrl_state  = rst_n ? state : RUN;
  assign mem_timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_ONE;
          end
        end
        MEM_WAIT: begin
          // Leaving on mem_ready or on mem_req dropping; neither is an error.
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_MAX) begin
            state     <= HALT;
            wait_cnt  <= '0;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 lu_evt;
  logic                 flush_evt;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] lu_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  // Events are counted only when they win the priority arbitration.
  assign flush_evt = (state != HALT) && !mem_stall && ex_branch_taken;
  assign lu_evt    = (state != HALT) && !mem_stall && !ex_branch_taken && lu_hazard;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en)    stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (lu_evt)    lu_cnt_q    <= lu_cnt_q + CNT_ONE;
      if (flush_evt) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_lu_count     = lu_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_lu_count     = '0;
  assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Latency: strobes compared in the same cycle as the inputs that produce them.
// Backpressure: stimulus is free-running; the model tracks memory stalls and timeouts itself.
module tb_pipeline_ctrl;

  localparam int RW   = 5;
  localparam int MAXW = 4;
  localparam int CW   = 32;
`ifdef PIPELINE_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble;
  logic [1:0]    ctrl_state;
  logic          mem_timeout;
  logic [CW-1:0] perf_stall_cycles, perf_lu_count, perf_flush_count;

  pipeline_ctrl #(
    .REG_ADDR_WIDTH (RW),
    .MEM_WAIT_MAX   (MAXW),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs1_addr       (id_rs1_addr),
    .id_rs2_addr       (id_rs2_addr),
    .id_rs1_used       (id_rs1_used),
    .id_rs2_used       (id_rs2_used),
    .ex_rd_addr        (ex_rd_addr),
    .ex_mem_read       (ex_mem_read),
    .ex_branch_taken   (ex_branch_taken),
    .mem_req           (mem_req),
    .mem_ready         (mem_ready),
    .pc_en             (pc_en),
    .ifid_en           (ifid_en),
    .idex_en           (idex_en),
    .exmem_en          (exmem_en),
    .ifid_flush        (ifid_flush),
    .idex_flush        (idex_flush),
    .memwb_bubble      (memwb_bubble),
    .ctrl_state        (ctrl_state),
    .mem_timeout       (mem_timeout),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_lu_count     (perf_lu_count),
    .perf_flush_count  (perf_flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_waits = number of consecutive memory-stalled cycles seen so far.
  bit          m_halted  = 1'b0;
  int          m_waits   = 0;
  bit          m_timeout = 1'b0;
  logic [31:0] m_stall   = '0;
  logic [31:0] m_lu      = '0;
  logic [31:0] m_fl      = '0;

  function automatic bit m_lu_match();
    return ex_mem_read && ex_rd_addr != 0 &&
           ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
            (id_rs2_used && id_rs2_addr == ex_rd_addr));
  endfunction

  function automatic bit m_memstall();
    return !m_halted && mem_req && !mem_ready;
  endfunction

  // {pc, ifid, idex, exmem, ifid_flush, idex_flush, memwb_bubble}
  function automatic logic [6:0] m_strobes();
    if (!rst_n)           return 7'b0000_111;
    if (m_halted)         return 7'b0000_001;
    if (m_memstall())     return 7'b0000_001;
    if (ex_branch_taken)  return 7'b1111_110;
    if (m_lu_match())     return 7'b0011_010;
    return 7'b1111_000;
  endfunction

  function automatic logic [1:0] m_state();
    if (!rst_n)      return 2'd0;
    if (m_halted)    return 2'd2;
    if (m_waits > 0) return 2'd1;
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_halted  <= 1'b0;
      m_waits   <= 0;
      m_timeout <= 1'b0;
      m_stall   <= '0;
      m_lu      <= '0;
      m_fl      <= '0;
    end else begin
      if (m_strobes() ==? 7'b0??????) m_stall <= m_stall + 1;
      if (!m_halted) begin
        if (m_memstall()) begin
          // MAXW stalled cycles already spent waiting plus one more: give up.
          if (m_waits == MAXW + 1 - 1 + 0 && m_waits >= 1 && m_waits == MAXW) begin
            m_halted  <= 1'b1;
            m_timeout <= 1'b1;
            m_waits   <= 0;
          end else begin
            m_waits <= m_waits + 1;
          end
        end else begin
          m_waits <= 0;
          if (ex_branch_taken)   m_fl <= m_fl + 1;
          else if (m_lu_match()) m_lu <= m_lu + 1;
        end
      end
    end
  end

  function automatic logic [31:0] pexp(input logic [31:0] v);
    return PERF_ON ? v : 32'd0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("strobes", {25'd0, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble},
            {25'd0, m_strobes()});
      check("ctrl_state", {30'd0, ctrl_state}, {30'd0, m_state()});
      check("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_timeout});
      check("perf_stall_cycles", perf_stall_cycles, pexp(m_stall));
      check("perf_lu_count", perf_lu_count, pexp(m_lu));
      check("perf_flush_count", perf_flush_count, pexp(m_fl));
    end
  end

  task automatic clear_in();
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    chk_on = 1'b1;

    // Reset-forced outputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check("rst_exmem_en", {31'd0, exmem_en}, 32'd0);
    check("rst_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    check("rst_idex_flush", {31'd0, idex_flush}, 32'd1);
    check("rst_state", {30'd0, ctrl_state}, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Load-use: lw x7 in EX, addi x8,x7,1 in ID.
    ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_rs1_used = 1'b1;
    @(negedge clk);
    check("lu_pc_en", {31'd0, pc_en}, 32'd0);
    check("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
    check("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    check("lu_idex_en", {31'd0, idex_en}, 32'd1);
    next_cycle();
    clear_in();
    @(negedge clk);
    check("lu_release_pc_en", {31'd0, pc_en}, 32'd1);
    check("lu_count", perf_lu_count, pexp(32'd1));

    // x0 destination and unused source never stall.
    next_cycle();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs1_used = 1'b1;
    @(negedge clk);
    check("x0_pc_en", {31'd0, pc_en}, 32'd1);
    next_cycle();
    ex_rd_addr = 5'd7; id_rs1_addr = 5'd3; id_rs2_addr = 5'd7; id_rs2_used = 1'b0;
    @(negedge clk);
    check("unused_pc_en", {31'd0, pc_en}, 32'd1);

    // Taken branch together with a load-use match.
    next_cycle();
    clear_in();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd7;
    id_rs1_addr = 5'd7; id_rs1_used = 1'b1;
    @(negedge clk);
    check("br_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    check("br_idex_flush", {31'd0, idex_flush}, 32'd1);
    check("br_pc_en", {31'd0, pc_en}, 32'd1);
    next_cycle();
    clear_in();
    @(negedge clk);
    check("br_flush_count", perf_flush_count, pexp(32'd1));
    check("br_lu_count", perf_lu_count, pexp(32'd1));

    // One-cycle reset, then a 3-cycle memory wait.
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mw_pc_en", {31'd0, pc_en}, 32'd0);
      check("mw_exmem_en", {31'd0, exmem_en}, 32'd0);
      check("mw_bubble", {31'd0, memwb_bubble}, 32'd1);
      if (i > 0) check("mw_state", {30'd0, ctrl_state}, 32'd1);
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("mw_ready_pc_en", {31'd0, pc_en}, 32'd1);
    check("mw_ready_bubble", {31'd0, memwb_bubble}, 32'd0);
    next_cycle();
    clear_in();
    @(negedge clk);
    check("mw_back_state", {30'd0, ctrl_state}, 32'd0);
    check("mw_stall_cycles", perf_stall_cycles, pexp(32'd3));

    // Zero-wait access.
    next_cycle();
    mem_req = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("zw_pc_en", {31'd0, pc_en}, 32'd1);
    check("zw_state", {30'd0, ctrl_state}, 32'd0);

    // Watchdog: one RUN stall cycle, then MAXW MEM_WAIT cycles, then HALT.
    next_cycle();
    mem_ready = 1'b0;
    repeat (MAXW) @(posedge clk);
    @(negedge clk);
    check("to_pre_state", {30'd0, ctrl_state}, 32'd1);
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    check("to_state", {30'd0, ctrl_state}, 32'd2);
    check("to_flag", {31'd0, mem_timeout}, 32'd1);
    check("to_pc_en", {31'd0, pc_en}, 32'd0);
    check("to_bubble", {31'd0, memwb_bubble}, 32'd1);
    repeat (3) next_cycle();
    @(negedge clk);
    check("to_stay_state", {30'd0, ctrl_state}, 32'd2);

    // Reset from HALT.
    next_cycle();
    rst_n = 1'b0;
    clear_in();
    @(negedge clk);
    check("rst2_exmem_en", {31'd0, exmem_en}, 32'd0);
    check("rst2_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    check("rst2_state", {30'd0, ctrl_state}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rec_state", {30'd0, ctrl_state}, 32'd0);
    check("rec_timeout", {31'd0, mem_timeout}, 32'd0);
    check("rec_stall_cycles", perf_stall_cycles, 32'd0);
    check("rec_lu_count", perf_lu_count, 32'd0);
    check("rec_flush_count", perf_flush_count, 32'd0);

    // Randomized traffic; the per-cycle compare process does the checking.
    repeat (3000) begin
      next_cycle();
      rst_n           = ($urandom_range(0, 249) != 0);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_rd_addr      = RW'($urandom_range(0, 3));
      id_rs1_addr     = RW'($urandom_range(0, 3));
      id_rs2_addr     = RW'($urandom_range(0, 3));
      id_rs1_used     = ($urandom_range(0, 1) == 1);
      id_rs2_used     = ($urandom_range(0, 1) == 1);
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 9) < 4);
    end
    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V core. It combines load-use hazard detection, EX-stage branch/jump redirect and multi-cycle data-memory wait into one prioritized set of per-stage enable/flush strobes. It also supervises memory latency with a watchdog that halts the core on timeout. It sits beside the pipeline registers in `riscv_core` and replaces the ad-hoc stall logic previously spread across ID and MEM.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5: register address width.
- `MEM_WAIT_MAX`, 15: maximum consecutive wait cycles before timeout; valid range 1..255.
- `CNT_WIDTH`, 32: width of each performance counter.

Ports:
- `clk`  in  1  single core clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `id_rs1_addr`  in  REG_ADDR_WIDTH  source register 1 of the instruction in ID.
- `id_rs2_addr`  in  REG_ADDR_WIDTH  source register 2 of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the instruction in ID actually reads that source.
- `ex_rd_addr`  in  REG_ADDR_WIDTH  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `ex_branch_taken`  in  1  a branch/jump resolved taken in EX this cycle.
- `mem_req`  in  1  the MEM stage is issuing a load/store this cycle.
- `mem_ready`  in  1  data memory completes the request this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`  out  1 each  stage register update enables.
- `ifid_flush`, `idex_flush`  out  1 each  load a bubble (NOP, all control 0) into that register.
- `memwb_bubble`  out  1  MEM/WB captures a bubble instead of MEM results.
- `ctrl_state`  out  2  current FSM state (`ctrl_state_e`).
- `mem_timeout`  out  1  sticky watchdog error flag.
- `perf_stall_cycles`, `perf_lu_count`, `perf_flush_count`  out  CNT_WIDTH each  performance counters.

## Operation
- States: RUN (0), MEM_WAIT (1), HALT (2). Encoding 3 is illegal and recovers to RUN on the next edge.
- `mem_stall = mem_req && !mem_ready` in RUN or MEM_WAIT.
- `lu_hazard = ex_mem_read && ex_rd_addr != 0 && ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr))`.
- Priority, highest first:
  1. **HALT.** All enables 0, all flushes 0, `memwb_bubble` = 1.
  2. **mem_stall.** `pc_en`, `ifid_en`, `idex_en`, `exmem_en` = 0; `memwb_bubble` = 1; no flush. A pending `ex_branch_taken` is held, because EX is frozen and re-evaluates after release.
  3. **ex_branch_taken.** All enables 1 (the PC loads the target), `ifid_flush` = 1, `idex_flush` = 1. A simultaneous `lu_hazard` is ignored because the ID instruction is squashed.
  4. **lu_hazard.** `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1, `idex_en` = 1, `exmem_en` = 1. This inserts exactly one bubble; the next cycle EX holds the bubble and the hazard clears.
  5. **Otherwise.** All enables 1, all flushes 0, `memwb_bubble` = 0.
- Flush takes precedence over enable in the pipeline registers.
- Transitions:
  - RUN → MEM_WAIT on `mem_stall`.
  - MEM_WAIT → RUN on `mem_ready`; that cycle is normal with no stall.
  - MEM_WAIT → HALT when the wait counter equals `MEM_WAIT_MAX` and `mem_ready` is 0.
  - HALT is left only by reset.
- Wait counter:
  - 8 bits.
  - Set to 1 on RUN → MEM_WAIT and increments each MEM_WAIT cycle.
  - Cleared on exit from MEM_WAIT and on reset.
- `mem_timeout` is set on entry to HALT and is cleared only by reset.
- `mem_req` dropping while in MEM_WAIT returns the FSM to RUN without an error.

## Timing
- The strobe decision is combinational from the inputs and the registered state, with zero latency. All registers update on the `clk` rising edge.
- Zero-wait memory (`mem_req` and `mem_ready` high in the same cycle) causes no stall.
- An N-cycle memory wait causes N stall cycles.
- Load-use costs exactly 1 cycle. A taken branch costs 2 bubbles.
- Reset (`rst_n` = 0 sampled at an edge): state RUN, wait counter 0, `mem_timeout` 0, all perf counters 0.
- While `rst_n` is low, outputs are forced regardless of the other inputs:
  - all enables = 0;
  - `ifid_flush` = `idex_flush` = `memwb_bubble` = 1;
  - `ctrl_state` = RUN.
- Reset asserted mid-MEM_WAIT or in HALT takes effect at the next edge.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined: the three counters are active.
  - `perf_stall_cycles` increments every cycle in which `pc_en` = 0 (excluding reset).
  - `perf_lu_count` increments once per load-use bubble.
  - `perf_flush_count` increments once per taken-branch flush.
  - All counters wrap at 2^CNT_WIDTH.
- Macro undefined: the counters are tied to 0 and no counter registers are synthesized. The ports remain present.

## Structure
- `core_pkg` gains the `ctrl_state_e` enum (RUN, MEM_WAIT, HALT) and `MEM_WAIT_MAX_DEFAULT`. It reuses the existing `REG_ADDR_WIDTH`.
- Sub-module `hazard_detect`: purely combinational `lu_hazard` compare, instantiated once.

## Test plan
- **Load-use:** EX `lw x7` (`ex_mem_read` = 1, rd = 7); ID `addi x8, x7, 1` (rs1 = 7, used) → for exactly 1 cycle `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1; `perf_lu_count` = 1.
- **x0 and unused source:**
  - rd = 0 with rs1 = 0 → no stall.
  - rd = 7 with rs2 = 7 but `id_rs2_used` = 0 → no stall.
- **Branch vs load-use:** `ex_branch_taken` = 1 together with a load-use match → `ifid_flush` = `idex_flush` = 1, `pc_en` = 1; `perf_lu_count` unchanged, `perf_flush_count` = 1.
- **Memory wait:** `mem_req` = 1 with `mem_ready` low for 3 cycles → 3 cycles of all enables 0 and `memwb_bubble` = 1; `ctrl_state` = MEM_WAIT; back to RUN on the ready cycle; `perf_stall_cycles` = 3.
- **Timeout:** `MEM_WAIT_MAX` = 4, `mem_ready` held 0 → HALT after 4 wait cycles; `mem_timeout` = 1; stays halted with `mem_ready` = 1.
- **Reset recovery:**
  - Assert `rst_n` = 0 for 1 cycle from HALT → state RUN, `mem_timeout` = 0, all counters 0.
  - While `rst_n` is low: all enables 0 and all flushes 1.
